// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: word-addressed data memory with a posted-store write buffer and load forwarding
module data_mem_ctrl #(
  parameter int AW    = 10,
  parameter int DEPTH = 4
) (
  input  logic                     CLK,
  input  logic                     RESET_N,
  input  logic                     MemRead,
  input  logic                     MemWrite,
  input  logic [31:0]              addr,
  input  logic [31:0]              wdata,
  output logic [31:0]              read_data,
  output logic [$clog2(DEPTH):0]   buf_count,
  output logic                     buf_empty,
  output logic                     misalign_err
);
  localparam int PW = $clog2(DEPTH);
  logic [31:0]   mem [2**AW];
  logic [AW-1:0] buf_idx [DEPTH];
  logic [31:0]   buf_data [DEPTH];
  logic [PW-1:0] head, tail, slot;
  logic [PW:0]   count;
  logic [AW-1:0] idx;
  logic          full, drain, enq, fwd_hit;
  logic [31:0]   fwd_data;
  logic          unused_addr;
  assign idx         = addr[AW+1:2];
  assign unused_addr = ^addr[31:AW+2];
  assign full        = count == (PW+1)'(DEPTH);
  // A load owns the single array port, so draining only happens on non-load cycles.
  assign drain       = RESET_N && !MemRead && count != '0;
  // A full buffer only accepts a store when the same edge frees the head slot.
  assign enq         = RESET_N && MemWrite && (!full || drain);
  assign buf_count   = count;
  assign buf_empty   = count == '0;
  assign read_data   = MemRead ? (fwd_hit ? fwd_data : mem[idx]) : '0;
  // Newest matching buffered store wins: later slots from head override earlier ones.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    slot     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      slot = head + PW'(i);
      if (RESET_N && (PW+1)'(i) < count && buf_idx[slot] == idx) begin
        fwd_hit  = 1'b1;
        fwd_data = buf_data[slot];
      end
    end
  end
  // Buffer pointers, occupancy and the sticky misalignment flag.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      misalign_err <= 1'b0;
    end else begin
      if (enq) tail <= tail + PW'(1);
      if (drain) head <= head + PW'(1);
      count <= count + (PW+1)'(enq) - (PW+1)'(drain);
      if ((MemRead || MemWrite) && addr[1:0] != 2'b00) misalign_err <= 1'b1;
    end
  end
  // Unreset storage: buffer slot capture on enqueue and array write on drain.
  always_ff @(posedge CLK) begin
    if (enq) begin
      buf_idx[tail]  <= idx;
      buf_data[tail] <= wdata;
    end
    if (drain) mem[buf_idx[head]] <= buf_data[head];
  end
endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb_data_mem_ctrl: directed checks of posting, forwarding, draining, misalignment and reset
module tb_data_mem_ctrl;
  logic        CLK = 1'b0;
  logic        RESET_N = 1'b0;
  logic        MemRead = 1'b0;
  logic        MemWrite = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] read_data;
  logic [2:0]  buf_count;
  logic        buf_empty;
  logic        misalign_err;
  int n_cmp = 0;
  int n_err = 0;

  data_mem_ctrl #(.AW(10), .DEPTH(4)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .MemRead(MemRead), .MemWrite(MemWrite),
    .addr(addr), .wdata(wdata), .read_data(read_data), .buf_count(buf_count),
    .buf_empty(buf_empty), .misalign_err(misalign_err)
  );

  always #5 CLK = ~CLK;

  task automatic drive(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
    MemRead = r; MemWrite = w; addr = a; wdata = d;
    #1;
  endtask

  task automatic tick;
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic test_reset;
    @(negedge CLK);
    drive(0, 0, 32'h40, 0);
    n_cmp++; if (buf_count !== 3'd0) begin n_err++; $display("FAIL rst_count got %0d want 0", buf_count); end
    n_cmp++; if (buf_empty !== 1'b1) begin n_err++; $display("FAIL rst_empty got %b want 1", buf_empty); end
    n_cmp++; if (misalign_err !== 1'b0) begin n_err++; $display("FAIL rst_misalign got %b want 0", misalign_err); end
    n_cmp++; if (read_data !== 32'h0) begin n_err++; $display("FAIL rst_rdata got %h want 0", read_data); end
    RESET_N = 1'b1;
    tick;
  endtask

  task automatic test_forward;
    drive(0, 1, 32'h40, 32'hDEADBEEF); tick;
    n_cmp++; if (buf_count !== 3'd1) begin n_err++; $display("FAIL fwd_count0 got %0d want 1", buf_count); end
    drive(1, 0, 32'h40, 0);
    n_cmp++; if (read_data !== 32'hDEADBEEF) begin n_err++; $display("FAIL fwd_rdata got %h want deadbeef", read_data); end
    tick;
    n_cmp++; if (buf_count !== 3'd1) begin n_err++; $display("FAIL fwd_nodrain got %0d want 1", buf_count); end
    drive(0, 0, 32'h40, 0);
    n_cmp++; if (read_data !== 32'h0) begin n_err++; $display("FAIL fwd_idle_rdata got %h want 0", read_data); end
    tick;
    n_cmp++; if (buf_empty !== 1'b1) begin n_err++; $display("FAIL fwd_empty got %b want 1", buf_empty); end
    drive(1, 0, 32'h40, 0);
    n_cmp++; if (read_data !== 32'hDEADBEEF) begin n_err++; $display("FAIL fwd_array got %h want deadbeef", read_data); end
    tick;
  endtask

  task automatic test_same_index;
    drive(0, 1, 32'h10, 32'd1); tick;
    drive(0, 1, 32'h10, 32'd2); tick;
    n_cmp++; if (buf_count !== 3'd1) begin n_err++; $display("FAIL same_count got %0d want 1", buf_count); end
    drive(1, 0, 32'h10, 0);
    n_cmp++; if (read_data !== 32'd2) begin n_err++; $display("FAIL same_fwd got %h want 2", read_data); end
    tick;
    drive(0, 0, 0, 0); tick; tick; tick;
    n_cmp++; if (buf_empty !== 1'b1) begin n_err++; $display("FAIL same_empty got %b want 1", buf_empty); end
    drive(1, 0, 32'h10, 0);
    n_cmp++; if (read_data !== 32'd2) begin n_err++; $display("FAIL same_array got %h want 2", read_data); end
    tick;
  endtask

  task automatic test_hold;
    drive(1, 1, 32'h40, 32'h11111111);
    n_cmp++; if (read_data !== 32'hDEADBEEF) begin n_err++; $display("FAIL rw_pre0 got %h want deadbeef", read_data); end
    tick;
    drive(1, 1, 32'h40, 32'h22222222);
    n_cmp++; if (read_data !== 32'h11111111) begin n_err++; $display("FAIL rw_pre1 got %h want 11111111", read_data); end
    tick;
    drive(1, 1, 32'h44, 32'h33333333); tick;
    n_cmp++; if (buf_count !== 3'd3) begin n_err++; $display("FAIL hold_count3 got %0d want 3", buf_count); end
    for (int i = 0; i < 2; i++) begin
      drive(1, 0, 32'h40, 0);
      n_cmp++; if (read_data !== 32'h22222222) begin n_err++; $display("FAIL hold_rdata%0d got %h want 22222222", i, read_data); end
      tick;
      n_cmp++; if (buf_count !== 3'd3) begin n_err++; $display("FAIL hold_count%0d got %0d want 3", i, buf_count); end
    end
    drive(0, 0, 0, 0); tick;
    n_cmp++; if (buf_count !== 3'd2) begin n_err++; $display("FAIL hold_idle got %0d want 2", buf_count); end
    tick; tick;
    n_cmp++; if (buf_empty !== 1'b1) begin n_err++; $display("FAIL hold_empty got %b want 1", buf_empty); end
    drive(1, 0, 32'h40, 0);
    n_cmp++; if (read_data !== 32'h22222222) begin n_err++; $display("FAIL hold_arr40 got %h want 22222222", read_data); end
    drive(1, 0, 32'h44, 0);
    n_cmp++; if (read_data !== 32'h33333333) begin n_err++; $display("FAIL hold_arr44 got %h want 33333333", read_data); end
    tick;
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 5; i++) begin
      drive(0, 1, 32'h200 + 32'(4 * i), 32'hA0 + 32'(i)); tick;
      n_cmp++; if (buf_count !== 3'd1) begin n_err++; $display("FAIL b2b_count%0d got %0d want 1", i, buf_count); end
    end
    drive(0, 0, 0, 0); tick;
    n_cmp++; if (buf_empty !== 1'b1) begin n_err++; $display("FAIL b2b_empty got %b want 1", buf_empty); end
    for (int i = 0; i < 5; i++) begin
      drive(1, 0, 32'h200 + 32'(4 * i), 0);
      n_cmp++; if (read_data !== 32'hA0 + 32'(i)) begin n_err++; $display("FAIL b2b_rd%0d got %h want %h", i, read_data, 32'hA0 + 32'(i)); end
      tick;
    end
  endtask

  task automatic test_misalign;
    drive(0, 0, 0, 0);
    n_cmp++; if (misalign_err !== 1'b0) begin n_err++; $display("FAIL mis_pre got %b want 0", misalign_err); end
    drive(1, 0, 32'h42, 0);
    n_cmp++; if (read_data !== 32'h22222222) begin n_err++; $display("FAIL mis_rdata got %h want 22222222", read_data); end
    tick;
    n_cmp++; if (misalign_err !== 1'b1) begin n_err++; $display("FAIL mis_set got %b want 1", misalign_err); end
    drive(0, 0, 0, 0); tick; tick;
    n_cmp++; if (misalign_err !== 1'b1) begin n_err++; $display("FAIL mis_sticky got %b want 1", misalign_err); end
  endtask

  task automatic test_reset_midstream;
    drive(1, 1, 32'h40, 32'h55); tick;
    drive(1, 1, 32'h40, 32'h66); tick;
    n_cmp++; if (buf_count !== 3'd2) begin n_err++; $display("FAIL mid_count got %0d want 2", buf_count); end
    drive(1, 0, 32'h40, 0);
    RESET_N = 1'b0;
    #1;
    n_cmp++; if (buf_count !== 3'd0) begin n_err++; $display("FAIL mid_rst_count got %0d want 0", buf_count); end
    n_cmp++; if (buf_empty !== 1'b1) begin n_err++; $display("FAIL mid_rst_empty got %b want 1", buf_empty); end
    n_cmp++; if (misalign_err !== 1'b0) begin n_err++; $display("FAIL mid_rst_misalign got %b want 0", misalign_err); end
    n_cmp++; if (read_data !== 32'h22222222) begin n_err++; $display("FAIL mid_rst_rdata got %h want 22222222", read_data); end
    drive(0, 1, 32'h40, 32'h77); tick;
    n_cmp++; if (buf_count !== 3'd0) begin n_err++; $display("FAIL mid_rst_noenq got %0d want 0", buf_count); end
    RESET_N = 1'b1;
    drive(0, 0, 0, 0); tick;
    drive(1, 0, 32'h40, 0);
    n_cmp++; if (read_data !== 32'h22222222) begin n_err++; $display("FAIL mid_old got %h want 22222222", read_data); end
    tick;
  endtask

  initial begin
    test_reset;
    test_forward;
    test_same_index;
    test_hold;
    test_back_to_back;
    test_misalign;
    test_reset_midstream;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/data_mem_ctrl.md
DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 Parameter: AW, 10, word-address width; the memory holds 2^AW 32-bit words.
REQ-002 Parameter: DEPTH, 4, number of write-buffer entries; it SHALL be a power of two, 2..16.
REQ-003 CLK  input  1  clock; all state SHALL update on its rising edge.
REQ-004 RESET_N  input  1  asynchronous, active-low reset.
REQ-005 MemRead  input  1  core data load request, valid for the current cycle.
REQ-006 MemWrite  input  1  core data store request, valid for the current cycle.
REQ-007 addr  input  32  core byte address (ALU result).
REQ-008 wdata  input  32  store data (register rs2 value).
REQ-009 read_data  output  32  load data returned to the core in the same cycle.
REQ-010 buf_count  output  $clog2(DEPTH)+1  number of valid write-buffer entries.
REQ-011 buf_empty  output  1  high when buf_count == 0.
REQ-012 misalign_err  output  1  sticky flag for a misaligned access.

Function
REQ-013 Word index SHALL be addr[AW+1:2]; addr[31:AW+2] SHALL be ignored (the address space wraps).
REQ-014 Storage SHALL be a single-port array of 2^AW x 32 bits, with one access (read or drain-write) per cycle; array contents SHALL NOT be reset.
REQ-015 Stores SHALL be posted: when MemWrite=1, {index, wdata} SHALL be enqueued at the buffer tail on the next rising edge; the store has zero-cycle latency as seen by the core.
REQ-016 Drain: on a rising edge with MemRead=0 and buffer non-empty, the head entry SHALL be written to the array and dequeued; oldest-first order.
REQ-017 When MemRead=1, the array port SHALL belong to the read; no drain SHALL occur that cycle.
REQ-018 read_data SHALL be combinational: with MemRead=1 it SHALL equal wdata of the newest valid buffer entry whose index matches, otherwise array[index].
REQ-019 With MemRead=0, read_data SHALL be 32'h0.
REQ-020 Enqueue and drain in the same edge: count SHALL stay unchanged; head and tail SHALL both advance.
REQ-021 Full: a store with the buffer full is always accompanied by a drain (MemRead=0), so overflow SHALL be impossible; buf_count SHALL never exceed DEPTH.
REQ-022 Head and tail pointers SHALL wrap modulo DEPTH.
REQ-023 MemRead=1 and MemWrite=1 together SHALL be treated as a read followed by a posted write: read_data uses the pre-store contents, the store is enqueued, and no drain occurs.
REQ-024 Multiple buffered stores to one index SHALL all drain in order, so the array ends with the newest value.
REQ-025 misalign_err SHALL set on an edge where (MemRead|MemWrite)=1 and addr[1:0]!=0; the access SHALL still proceed using the word index; the flag clears only on reset.
REQ-026 buf_count and buf_empty SHALL be registered-state outputs with no combinational path from the inputs.

Reset
REQ-027 RESET_N=0 SHALL immediately clear head, tail, and count, set buf_empty=1, and clear misalign_err; buffered stores not yet drained SHALL be discarded.
REQ-028 While reset is asserted, read_data SHALL reflect the array only (buffer invalid), and no enqueue or drain SHALL occur.
REQ-029 Deassertion SHALL be synchronised by the integrator; the block SHALL operate from the first rising edge after RESET_N=1.

Verification
REQ-030 Store 0x00000040<-0xDEADBEEF, then a load from 0x40 in the next cycle -> read_data=0xDEADBEEF, forwarded from the buffer, buf_count=1.
REQ-031 Stores 0x10<-1 and 0x10<-2, then a load from 0x10 -> returns 2; after idle cycles, buf_empty=1 and a load from 0x10 returns 2 from the array.
REQ-032 Loads issued every cycle after 3 stores -> buf_count stays 3 and no drain occurs; the first idle cycle lowers it to 2.
REQ-033 Five back-to-back stores with DEPTH=4 and no loads -> buf_count reaches 1 and stays at 1 or below; all five values are present after draining.
REQ-034 Load from 0x42 -> misalign_err=1 after the edge, data from word 0x10; it stays set until RESET_N=0.
REQ-035 Two buffered stores, then RESET_N pulsed low mid-stream -> buf_count=0 immediately, the array is unchanged, and a subsequent load returns the old array value.
